// File: rtl/cycle_sequencer_pkg.sv
// Shared decoder/control constants: decoder STATE_* codes, OP_* opcodes and the
// sequencer FSM encoding (RUN, HALTED, WAIT).
package cycle_sequencer_pkg;

  localparam logic [3:0] STATE_FETCH_PC   = 4'h0;
  localparam logic [3:0] STATE_FETCH_INST = 4'h1;
  localparam logic [3:0] STATE_LOAD_ADDR  = 4'h2;
  localparam logic [3:0] STATE_LOAD_DATA  = 4'h3;
  localparam logic [3:0] STATE_STORE      = 4'h4;
  localparam logic [3:0] STATE_ALU_EXEC   = 4'h5;
  localparam logic [3:0] STATE_JUMP       = 4'h6;
  localparam logic [3:0] STATE_OUT        = 4'h7;
  localparam logic [3:0] STATE_NEXT       = 4'hE;
  localparam logic [3:0] STATE_HALT       = 4'hF;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    SEQ_RUN    = 2'd0,
    SEQ_HALTED = 2'd1,
    SEQ_WAIT   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/cycle_sequencer_step_edge_detect.sv
// Two-flop synchronizer plus rising-edge pulse for the single-step button.
// Only built when SEQ_SINGLE_STEP_EN is defined.
`ifdef SEQ_SINGLE_STEP_EN
module step_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic pulse_o
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign pulse_o = sync2_q & ~prev_q;

endmodule
`endif

// File: rtl/cycle_sequencer.sv
// Micro-cycle counter and opcode latch feeding the instruction decoder.
// Optional single-step mode (WAIT state, step/step_mode ports) under SEQ_SINGLE_STEP_EN.
module cycle_sequencer
  import cycle_sequencer_pkg::*;
#(
  parameter int CYCLE_W   = 4,
  parameter int MAX_CYCLE = 7,
  parameter int OP_W      = 4,
  parameter int BUS_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [3:0]         state,
  input  logic [BUS_W-1:0]   bus,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic               step_mode,
  input  logic               step,
`endif
  output logic [CYCLE_W-1:0] cycle,
  output logic [OP_W-1:0]    opcode,
  output logic               halted,
  output logic               overrun
);

  seq_state_e         fsm_q, fsm_d;
  logic [CYCLE_W-1:0] cycle_q, cycle_d;
  logic [OP_W-1:0]    opcode_q, opcode_d;
  logic               overrun_q, overrun_d;

  // Only the opcode nibble of the instruction byte is decoded here.
  logic unused_bus_bits;
  assign unused_bus_bits = ^bus[BUS_W-OP_W-1:0];

`ifdef SEQ_SINGLE_STEP_EN
  logic step_pulse;

  step_edge_detect u_step (
    .clk     (clk),
    .reset   (reset),
    .async_i (step),
    .pulse_o (step_pulse)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fsm_q     <= SEQ_RUN;
      cycle_q   <= '0;
      opcode_q  <= '0;
      overrun_q <= 1'b0;
    end else if (en) begin
      fsm_q     <= fsm_d;
      cycle_q   <= cycle_d;
      opcode_q  <= opcode_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    cycle_d   = cycle_q;
    opcode_d  = opcode_q;
    overrun_d = overrun_q;
    case (fsm_q)
      SEQ_RUN: begin
        if (state == STATE_HALT) begin
          fsm_d = SEQ_HALTED;
        end else begin
          if (state == STATE_FETCH_INST) opcode_d = bus[BUS_W-1 -: OP_W];
          if (state == STATE_NEXT) begin
            cycle_d = '0;
          end else if (cycle_q == CYCLE_W'(MAX_CYCLE)) begin
            cycle_d   = '0;
            overrun_d = 1'b1;
          end else begin
            cycle_d = cycle_q + CYCLE_W'(1);
          end
`ifdef SEQ_SINGLE_STEP_EN
          // Counter only returns to 0 at an instruction boundary (NEXT or wrap).
          if (step_mode && cycle_d == '0) fsm_d = SEQ_WAIT;
`endif
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      SEQ_WAIT: begin
        if (state == STATE_HALT)            fsm_d = SEQ_HALTED;
        else if (!step_mode || step_pulse)  fsm_d = SEQ_RUN;
      end
`endif
      default: ;
    endcase
  end

  assign cycle   = cycle_q;
  assign opcode  = opcode_q;
  assign halted  = (fsm_q == SEQ_HALTED);
  assign overrun = overrun_q;

endmodule
